// File: rtl/cam_pkg.sv
// Shared types and constants for the camera frame writer: FSM encoding,
// RGB444 -> RGB111 bit selection and the default stored frame geometry.
package cam_pkg;

  localparam int unsigned CAM_SCREEN_X_DEF = 160;
  localparam int unsigned CAM_SCREEN_Y_DEF = 120;

  // Channel MSB positions inside the two RGB444 bytes (xxxxRRRR, GGGGBBBB).
  localparam int unsigned R_BIT = 3;
  localparam int unsigned G_BIT = 7;
  localparam int unsigned B_BIT = 3;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    LINE_IDLE  = 2'd1,
    BYTE1      = 2'd2,
    BYTE2      = 2'd3
  } cam_state_e;

  function automatic logic [2:0] rgb444_to_rgb111(input logic [7:0] byte1,
                                                  input logic [7:0] byte2);
    return {byte1[R_BIT], byte2[G_BIT], byte2[B_BIT]};
  endfunction

endpackage

// File: rtl/cam_frame_writer_if.sv
// Camera pin bundle plus the frame-buffer write port driven by the writer.
interface cam_frame_writer_if #(
  parameter int unsigned AW = 15,
  parameter int unsigned DW = 3
);
  logic          cam_pclk;
  logic          cam_vsync;
  logic          cam_href;
  logic [7:0]    cam_data;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_we;
  logic          frame_done;

  modport master (
    input  cam_pclk, cam_vsync, cam_href, cam_data,
    output mem_addr, mem_data, mem_we, frame_done
  );

  modport slave (
    output cam_pclk, cam_vsync, cam_href, cam_data,
    input  mem_addr, mem_data, mem_we, frame_done
  );
endinterface

// File: rtl/cam_sync_edge.sv
// Two-flop synchronizer for a slow external level, with registered one-clk
// rising and falling edge pulses derived from the synchronized value.
module cam_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
    prev_d = sync_q;
    rise_d = sync_q & ~prev_q;
    fall_d = ~sync_q & prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/cam_frame_writer.sv
// Captures an RGB444 two-byte camera stream and writes RGB111 pixels
// linearly into the frame buffer, gated to the stored window size.
module cam_frame_writer
  import cam_pkg::*;
#(
  parameter int unsigned CAM_SCREEN_X = CAM_SCREEN_X_DEF,
  parameter int unsigned CAM_SCREEN_Y = CAM_SCREEN_Y_DEF,
  parameter int unsigned AW           = 15,
  parameter int unsigned DW           = 3
) (
  input logic                clk,
  input logic                rst,
  cam_frame_writer_if.master bus
);

  localparam int unsigned   PIX_TOTAL = CAM_SCREEN_X * CAM_SCREEN_Y;
  localparam int unsigned   CW        = $clog2(CAM_SCREEN_X + 1);
  localparam int unsigned   RW        = $clog2(CAM_SCREEN_Y + 1);
  localparam logic [AW-1:0] ADDR_FULL = AW'(PIX_TOTAL);
  localparam logic [CW-1:0] COL_MAX   = CW'(CAM_SCREEN_X);
  localparam logic [RW-1:0] ROW_MAX   = RW'(CAM_SCREEN_Y);

  logic pclk_rise;
  logic pclk_fall_unused;
  logic vsync_rise;
  logic vsync_fall;

  cam_sync_edge u_pclk_sync (
    .clk    (clk),
    .rst    (rst),
    .d_in   (bus.cam_pclk),
    .rise_o (pclk_rise),
    .fall_o (pclk_fall_unused)
  );

  cam_sync_edge u_vsync_sync (
    .clk    (clk),
    .rst    (rst),
    .d_in   (bus.cam_vsync),
    .rise_o (vsync_rise),
    .fall_o (vsync_fall)
  );

  // href/data get the same two flops as pclk so all three line up at pclk_rise.
  logic       href_meta_q, href_meta_d, href_q, href_d;
  logic [7:0] data_meta_q, data_meta_d, data_q, data_d;

  always_comb begin
    href_meta_d = bus.cam_href;
    href_d      = href_meta_q;
    data_meta_d = bus.cam_data;
    data_d      = data_meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      href_meta_q <= 1'b0;
      href_q      <= 1'b0;
      data_meta_q <= 8'h00;
      data_q      <= 8'h00;
    end else begin
      href_meta_q <= href_meta_d;
      href_q      <= href_d;
      data_meta_q <= data_meta_d;
      data_q      <= data_d;
    end
  end

  cam_state_e    state_q, state_d;
  logic [7:0]    byte1_q, byte1_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] mem_data_q, mem_data_d;
  logic          mem_we_q, mem_we_d;
  logic          frame_done_q, frame_done_d;
  logic          write_ok_s;
  logic [RW-1:0] row_inc_s;

  always_comb begin
    write_ok_s = (col_q < COL_MAX) && (row_q < ROW_MAX) && (addr_q != ADDR_FULL);
    row_inc_s  = (row_q != ROW_MAX) ? (row_q + RW'(1)) : row_q;

    state_d      = state_q;
    byte1_d      = byte1_q;
    col_d        = col_q;
    row_d        = row_q;
    mem_data_d   = mem_data_q;
    mem_we_d     = 1'b0;
    frame_done_d = 1'b0;
    // Address advances the cycle after the write strobe, so mem_addr holds
    // the pre-increment value while mem_we is high.
    if (mem_we_q) begin
      addr_d = addr_q + AW'(1);
    end else begin
      addr_d = addr_q;
    end

    if ((state_q != WAIT_FRAME) && vsync_rise) begin
      frame_done_d = 1'b1;
      state_d      = WAIT_FRAME;
    end else begin
      case (state_q)
        WAIT_FRAME: begin
          if (vsync_fall) begin
            addr_d  = {AW{1'b0}};
            col_d   = {CW{1'b0}};
            row_d   = {RW{1'b0}};
            state_d = LINE_IDLE;
          end else begin
            state_d = WAIT_FRAME;
          end
        end
        LINE_IDLE: begin
          col_d = {CW{1'b0}};
          if (pclk_rise && href_q) begin
            byte1_d = data_q;
            state_d = BYTE2;
          end else begin
            state_d = LINE_IDLE;
          end
        end
        BYTE2: begin
          if (pclk_rise && href_q) begin
            if (write_ok_s) begin
              mem_we_d   = 1'b1;
              mem_data_d = DW'(rgb444_to_rgb111(byte1_q, data_q));
            end else begin
              mem_we_d   = 1'b0;
            end
            if (col_q != COL_MAX) begin
              col_d = col_q + CW'(1);
            end else begin
              col_d = col_q;
            end
            state_d = BYTE1;
          end else if (pclk_rise) begin
            // Odd byte count: the dangling first byte is dropped.
            row_d   = row_inc_s;
            state_d = LINE_IDLE;
          end else begin
            state_d = BYTE2;
          end
        end
        BYTE1: begin
          if (pclk_rise && href_q) begin
            byte1_d = data_q;
            state_d = BYTE2;
          end else if (pclk_rise) begin
            row_d   = row_inc_s;
            state_d = LINE_IDLE;
          end else begin
            state_d = BYTE1;
          end
        end
        default: begin
          state_d = WAIT_FRAME;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= WAIT_FRAME;
      byte1_q      <= 8'h00;
      col_q        <= {CW{1'b0}};
      row_q        <= {RW{1'b0}};
      addr_q       <= {AW{1'b0}};
      mem_data_q   <= {DW{1'b0}};
      mem_we_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte1_q      <= byte1_d;
      col_q        <= col_d;
      row_q        <= row_d;
      addr_q       <= addr_d;
      mem_data_q   <= mem_data_d;
      mem_we_q     <= mem_we_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.mem_addr   = addr_q;
  assign bus.mem_data   = mem_data_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_cam_frame_writer.sv
// Directed bench for cam_frame_writer on a reduced 16x4 window, driving the
// camera pins at clk/4 and logging every RAM write for comparison.
module tb_cam_frame_writer;

  localparam int unsigned X  = 16;
  localparam int unsigned Y  = 4;
  localparam int unsigned AW = 15;
  localparam int unsigned DW = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cam_frame_writer_if #(.AW(AW), .DW(DW)) bus ();

  cam_frame_writer #(
    .CAM_SCREEN_X (X),
    .CAM_SCREEN_Y (Y),
    .AW           (AW),
    .DW           (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  logic [AW-1:0] wr_a[$];
  logic [DW-1:0] wr_d[$];

  typedef struct {
    logic [7:0] b1;
    logic [7:0] b2;
    logic [2:0] exp;
  } vec_t;
  vec_t vecs[7];

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_a.push_back(bus.mem_addr);
      wr_d.push_back(bus.mem_data);
    end
    if (bus.frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int idx, input int exp_a, input logic [2:0] exp_d);
    if (idx < wr_a.size()) begin
      check({tag, "_addr"}, 32'(wr_a[idx]), 32'(exp_a));
      check({tag, "_data"}, 32'(wr_d[idx]), 32'(exp_d));
    end else begin
      checks++;
      errors++;
      $display("FAIL %s: write %0d missing, got %0d writes", tag, idx, wr_a.size());
    end
  endtask

  task automatic cam_byte(input logic [7:0] d, input logic h);
    bus.cam_pclk = 1'b0;
    bus.cam_data = d;
    bus.cam_href = h;
    repeat (2) @(negedge clk);
    bus.cam_pclk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic pixel(input logic [7:0] b1, input logic [7:0] b2);
    cam_byte(b1, 1'b1);
    cam_byte(b2, 1'b1);
  endtask

  task automatic line_end();
    repeat (2) cam_byte(8'h00, 1'b0);
  endtask

  task automatic frame_start();
    bus.cam_vsync = 1'b1;
    repeat (2) cam_byte(8'h00, 1'b0);
    bus.cam_vsync = 1'b0;
    repeat (2) cam_byte(8'h00, 1'b0);
  endtask

  task automatic frame_end();
    bus.cam_vsync = 1'b1;
    repeat (3) cam_byte(8'h00, 1'b0);
  endtask

  task automatic clear_log();
    wr_a.delete();
    wr_d.delete();
  endtask

  initial begin
    int fd_base;
    int lat;
    int max_a;

    vecs[0] = '{8'h0F, 8'hFF, 3'b111};
    vecs[1] = '{8'h08, 8'h00, 3'b100};
    vecs[2] = '{8'h00, 8'h80, 3'b010};
    vecs[3] = '{8'h00, 8'h08, 3'b001};
    vecs[4] = '{8'hF7, 8'h77, 3'b000};
    vecs[5] = '{8'h0A, 8'h5C, 3'b101};
    vecs[6] = '{8'h05, 8'h88, 3'b011};

    bus.cam_pclk  = 1'b0;
    bus.cam_vsync = 1'b0;
    bus.cam_href  = 1'b0;
    bus.cam_data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_data", 32'(bus.mem_data), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    rst = 1'b0;

    // No vsync fall yet: pixels must be ignored.
    pixel(8'h0F, 8'hFF);
    line_end();
    check("no_write_before_vsync", 32'(wr_a.size()), 32'd0);

    // Frame 1: table of pixel patterns, then odd-byte line and its follower.
    frame_start();
    clear_log();
    for (int i = 0; i < 7; i++) pixel(vecs[i].b1, vecs[i].b2);
    line_end();
    check("f1_table_count", 32'(wr_a.size()), 32'd7);
    for (int i = 0; i < 7; i++) check_wr($sformatf("f1_vec%0d", i), i, i, vecs[i].exp);

    cam_byte(8'h08, 1'b1);
    cam_byte(8'h80, 1'b1);
    cam_byte(8'h0F, 1'b1);
    line_end();
    pixel(8'h00, 8'h08);
    line_end();
    check("f1_total_count", 32'(wr_a.size()), 32'd9);
    check_wr("odd_line_px", 7, 7, 3'b110);
    check_wr("after_odd_px", 8, 8, 3'b001);
    fd_base = fd_cnt;
    frame_end();
    check("f1_frame_done", 32'(fd_cnt - fd_base), 32'd1);

    // Frame 2: over-long first line, then more lines than the window holds.
    frame_start();
    clear_log();
    for (int i = 0; i < 20; i++) pixel(8'h0F, 8'hFF);
    line_end();
    check("long_line_count", 32'(wr_a.size()), 32'(X));
    for (int ln = 1; ln < 6; ln++) begin
      for (int i = 0; i < int'(X); i++) pixel(8'h08, 8'h00);
      line_end();
    end
    check("full_frame_count", 32'(wr_a.size()), 32'(X * Y));
    check_wr("line1_first_px", 16, 16, 3'b100);
    check_wr("last_px", 63, 63, 3'b100);
    max_a = 0;
    foreach (wr_a[i]) if (int'(wr_a[i]) > max_a) max_a = int'(wr_a[i]);
    check("max_addr", 32'(max_a), 32'(X * Y - 1));
    check("addr_saturated", 32'(bus.mem_addr), 32'(X * Y));
    fd_base = fd_cnt;
    frame_end();
    check("f2_frame_done", 32'(fd_cnt - fd_base), 32'd1);

    // Frame 3: reset mid-line, no writes until the next vsync falling edge.
    frame_start();
    clear_log();
    for (int i = 0; i < int'(X); i++) pixel(8'h00, 8'h80);
    line_end();
    for (int i = 0; i < 5; i++) pixel(8'h00, 8'h80);
    cam_byte(8'h0F, 1'b1);
    check("pre_rst_addr", 32'(bus.mem_addr), 32'd21);
    check("pre_rst_data", 32'(bus.mem_data), 32'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
    check("mid_rst_data", 32'(bus.mem_data), 32'd0);
    check("mid_rst_we", 32'(bus.mem_we), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_log();
    cam_byte(8'hFF, 1'b1);
    for (int i = 6; i < int'(X); i++) pixel(8'h0F, 8'hFF);
    line_end();
    for (int i = 0; i < int'(X); i++) pixel(8'h0F, 8'hFF);
    line_end();
    check("post_rst_no_write", 32'(wr_a.size()), 32'd0);
    fd_base = fd_cnt;
    frame_start();
    check("post_rst_no_frame_done", 32'(fd_cnt - fd_base), 32'd0);

    // New frame: measure pin-to-strobe latency on the first pixel.
    cam_byte(8'h0A, 1'b1);
    bus.cam_pclk = 1'b0;
    bus.cam_data = 8'h5C;
    bus.cam_href = 1'b1;
    repeat (2) @(negedge clk);
    bus.cam_pclk = 1'b1;
    lat = 0;
    while (bus.mem_we !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check("we_latency", 32'(lat), 32'd4);
    repeat (2) @(negedge clk);
    check_wr("new_frame_px0", 0, 0, 3'b101);

    // vsync rise on the same clk as the byte2 sample: no write, frame_done.
    cam_byte(8'h0F, 1'b1);
    bus.cam_pclk = 1'b0;
    bus.cam_data = 8'hFF;
    bus.cam_href = 1'b1;
    repeat (2) @(negedge clk);
    fd_base = fd_cnt;
    bus.cam_pclk  = 1'b1;
    bus.cam_vsync = 1'b1;
    repeat (8) @(negedge clk);
    check("simul_no_write", 32'(wr_a.size()), 32'd1);
    check("simul_frame_done", 32'(fd_cnt - fd_base), 32'd1);
    repeat (4) cam_byte(8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
